// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and BCD helper for the seven-segment scan reader.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] NIB_BLANK = 4'hA;
    localparam logic [3:0] NIB_ERR   = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    // Any non-decimal nibble (blank or error) makes the binary value 0.
    function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
        logic [13:0] result;
        if (bcd[15:12] > 4'd9 || bcd[11:8] > 4'd9 || bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9) begin
            result = 14'd0;
        end else begin
            result = 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100
                   + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment pattern to BCD nibble decoder.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        nibble = NIB_ERR;
        valid  = 1'b1;
        case (pattern)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: nibble = NIB_BLANK;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Reads a scanned 4-digit seven-segment display back into BCD frames and detects blanking.
// Optional binary output value_bin enabled by defining SEG_READER_BIN_OUT_EN.
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int SETTLE_CYC = 1000,
    parameter int BLANK_CYC  = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic        frame_valid,
    output logic [15:0] value_bcd,
    output logic        frame_err,
    output logic        blank
`ifdef SEG_READER_BIN_OUT_EN
    ,
    output logic [13:0] value_bin
`endif
);

    localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
    localparam int BCNT_W = $clog2(BLANK_CYC + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [BCNT_W-1:0] BLANK_MAX   = BCNT_W'(BLANK_CYC);

    logic [6:0] seg_meta_reg, s_seg;
    logic [3:0] an_meta_reg, s_an;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_reg <= SEG_BLANK;
            s_seg        <= SEG_BLANK;
            an_meta_reg  <= 4'hF;
            s_an         <= 4'hF;
        end else begin
            seg_meta_reg <= seg;
            s_seg        <= seg_meta_reg;
            an_meta_reg  <= an;
            s_an         <= an_meta_reg;
        end
    end

    logic [3:0] an_low;
    logic       sel_valid;
    logic       all_off;

    assign an_low    = ~s_an;
    assign sel_valid = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
    assign all_off   = (s_an == 4'hF);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       cur_an_reg, cur_an_next;
    logic [6:0]       cur_seg_reg, cur_seg_next;
    logic             changed;
    logic             latch_en;

    assign changed = (s_an != cur_an_reg) || (s_seg != cur_seg_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            cur_an_reg  <= 4'hF;
            cur_seg_reg <= SEG_BLANK;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cur_an_reg  <= cur_an_next;
            cur_seg_reg <= cur_seg_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cur_an_next  = cur_an_reg;
        cur_seg_next = cur_seg_reg;
        latch_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    cur_an_next  = s_an;
                    cur_seg_next = s_seg;
                    cnt_next     = CNT_W'(1);
                    state_next   = SETTLE;
                end else begin
                    cnt_next = '0;
                end
            end
            SETTLE: begin
                if (changed) begin
                    cur_an_next  = s_an;
                    cur_seg_next = s_seg;
                    if (sel_valid) begin
                        cnt_next = CNT_W'(1);
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end else if (cnt_reg == SETTLE_LAST) begin
                    latch_en   = 1'b1;
                    cnt_next   = '0;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HOLD: begin
                // A change while holding restarts acquisition exactly as from IDLE.
                if (changed) begin
                    if (sel_valid) begin
                        cur_an_next  = s_an;
                        cur_seg_next = s_seg;
                        cnt_next     = CNT_W'(1);
                        state_next   = SETTLE;
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic [3:0] dec_nibble;
    logic       dec_valid;

    seg7_decode u_decode (
        .pattern (cur_seg_reg),
        .nibble  (dec_nibble),
        .valid   (dec_valid)
    );

    // cur_an_reg has exactly one low bit whenever latch_en is set.
    logic [3:0] latch_mask;
    assign latch_mask = latch_en ? ~cur_an_reg : 4'd0;

    logic [3:0] slot_reg [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg[gi] <= 4'd0;
                end else if (latch_mask[gi]) begin
                    slot_reg[gi] <= dec_nibble;
                end
            end
        end
    endgenerate

    logic [BCNT_W-1:0] blank_cnt_reg, blank_cnt_next;
    logic [3:0]        digit_seen_reg, digit_seen_next;
    logic              pend_err_reg, pend_err_next;
    logic              blank_next;
    logic              blank_enter;
    logic              frame_done;
    logic [15:0]       frame_bcd;

    assign frame_done  = (digit_seen_reg == 4'hF);
    assign blank_enter = all_off && !blank && (blank_cnt_reg == BLANK_MAX - BCNT_W'(1));
    assign frame_bcd   = {slot_reg[3], slot_reg[2], slot_reg[1], slot_reg[0]};

    always_comb begin
        blank_cnt_next = '0;
        if (all_off) begin
            blank_cnt_next = (blank_cnt_reg == BLANK_MAX) ? blank_cnt_reg
                                                          : blank_cnt_reg + BCNT_W'(1);
        end
        digit_seen_next = ((frame_done || blank_enter) ? 4'd0 : digit_seen_reg) | latch_mask;
        pend_err_next   = ((frame_done || blank_enter) ? 1'b0 : pend_err_reg)
                        | (latch_en & ~dec_valid);
        blank_next      = blank_enter ? 1'b1 : (latch_en ? 1'b0 : blank);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt_reg  <= '0;
            digit_seen_reg <= 4'd0;
            pend_err_reg   <= 1'b0;
            blank          <= 1'b0;
            frame_valid    <= 1'b0;
            value_bcd      <= 16'd0;
            frame_err      <= 1'b0;
        end else begin
            blank_cnt_reg  <= blank_cnt_next;
            digit_seen_reg <= digit_seen_next;
            pend_err_reg   <= pend_err_next;
            blank          <= blank_next;
            frame_valid    <= frame_done;
            if (frame_done) begin
                value_bcd <= frame_bcd;
                frame_err <= pend_err_reg;
            end
        end
    end

`ifdef SEG_READER_BIN_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_bin <= 14'd0;
        end else if (frame_done) begin
            value_bin <= bcd_to_bin(frame_bcd);
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed self-checking bench for seg_scan_reader (SETTLE_CYC=4, BLANK_CYC=64).
module tb_seg_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic        frame_valid;
    logic [15:0] value_bcd;
    logic        frame_err;
    logic        blank;
`ifdef SEG_READER_BIN_OUT_EN
    logic [13:0] value_bin;
`endif

    int checks = 0;
    int failures = 0;
    int fv_count = 0;
    int fv_start;

    logic [6:0] pat [10];

    seg_scan_reader #(
        .SETTLE_CYC (4),
        .BLANK_CYC  (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .frame_valid (frame_valid),
        .value_bcd   (value_bcd),
        .frame_err   (frame_err),
        .blank       (blank)
`ifdef SEG_READER_BIN_OUT_EN
        ,
        .value_bin   (value_bin)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_count++;
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(4'hF, 7'h7F, n);
    endtask

    task automatic scan(input logic [6:0] p3, p2, p1, p0, input int n);
        hold(4'h7, p3, n);
        hold(4'hB, p2, n);
        hold(4'hD, p1, n);
        hold(4'hE, p0, n);
    endtask

    task automatic test_reset;
        checks++;
        if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        checks++;
        if (value_bcd !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", value_bcd); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        checks++;
        if (blank !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b exp=0", blank); end
        $display("reset: fv=%b bcd=%h err=%b blank=%b", frame_valid, value_bcd, frame_err, blank);
    endtask

    task automatic test_basic;
        fv_start = fv_count;
        scan(pat[1], pat[2], pat[3], pat[4], 16);
        idle(8);
        checks++;
        if (fv_count - fv_start !== 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", fv_count - fv_start); end
        checks++;
        if (value_bcd !== 16'h1234) begin failures++; $display("FAIL basic_bcd got=%h exp=1234", value_bcd); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", frame_err); end
        checks++;
        if (blank !== 1'b0) begin failures++; $display("FAIL basic_blank got=%b exp=0", blank); end
`ifdef SEG_READER_BIN_OUT_EN
        checks++;
        if (value_bin !== 14'd1234) begin failures++; $display("FAIL basic_bin got=%0d exp=1234", value_bin); end
`endif
        $display("basic: frames=%0d bcd=%h err=%b", fv_count - fv_start, value_bcd, frame_err);
    endtask

    task automatic glitch_digit(input logic [3:0] a, input logic [6:0] p);
        hold(a, p, 3);
        hold(a, 7'h55, 2);
        hold(a, p, 11);
    endtask

    task automatic test_glitch;
        fv_start = fv_count;
        glitch_digit(4'h7, pat[5]);
        glitch_digit(4'hB, pat[6]);
        glitch_digit(4'hD, pat[7]);
        glitch_digit(4'hE, pat[8]);
        idle(8);
        checks++;
        if (fv_count - fv_start !== 1) begin failures++; $display("FAIL glitch_pulses got=%0d exp=1", fv_count - fv_start); end
        checks++;
        if (value_bcd !== 16'h5678) begin failures++; $display("FAIL glitch_bcd got=%h exp=5678", value_bcd); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL glitch_err got=%b exp=0", frame_err); end
        $display("glitch: frames=%0d bcd=%h err=%b", fv_count - fv_start, value_bcd, frame_err);
    endtask

    task automatic test_short_window;
        fv_start = fv_count;
        hold(4'h7, pat[1], 16);
        hold(4'hB, pat[2], 16);
        hold(4'hD, pat[3], 3);
        hold(4'hE, pat[4], 16);
        idle(8);
        checks++;
        if (fv_count - fv_start !== 0) begin failures++; $display("FAIL short_pulses got=%0d exp=0", fv_count - fv_start); end
        checks++;
        if (value_bcd !== 16'h5678) begin failures++; $display("FAIL short_bcd got=%h exp=5678", value_bcd); end
        $display("short: frames=%0d bcd=%h", fv_count - fv_start, value_bcd);
    endtask

    task automatic test_multi_low;
        fv_start = fv_count;
        hold(4'hC, pat[9], 70);
        checks++;
        if (blank !== 1'b0) begin failures++; $display("FAIL multi_blank got=%b exp=0", blank); end
        checks++;
        if (fv_count - fv_start !== 0) begin failures++; $display("FAIL multi_pulses got=%0d exp=0", fv_count - fv_start); end
        $display("multi_low: blank=%b frames=%0d", blank, fv_count - fv_start);
    endtask

    task automatic test_blank;
        fv_start = fv_count;
        hold(4'h7, pat[0], 16);
        hold(4'hB, pat[1], 16);
        idle(60);
        checks++;
        if (blank !== 1'b0) begin failures++; $display("FAIL blank_early got=%b exp=0", blank); end
        idle(10);
        checks++;
        if (blank !== 1'b1) begin failures++; $display("FAIL blank_set got=%b exp=1", blank); end
        checks++;
        if (fv_count - fv_start !== 0) begin failures++; $display("FAIL blank_pulses got=%0d exp=0", fv_count - fv_start); end
        hold(4'h7, pat[0], 16);
        checks++;
        if (blank !== 1'b0) begin failures++; $display("FAIL blank_clear got=%b exp=0", blank); end
        hold(4'hB, pat[1], 16);
        hold(4'hD, pat[5], 16);
        hold(4'hE, pat[0], 16);
        idle(8);
        checks++;
        if (fv_count - fv_start !== 1) begin failures++; $display("FAIL blank_frame got=%0d exp=1", fv_count - fv_start); end
        checks++;
        if (value_bcd !== 16'h0150) begin failures++; $display("FAIL blank_bcd got=%h exp=0150", value_bcd); end
`ifdef SEG_READER_BIN_OUT_EN
        checks++;
        if (value_bin !== 14'd150) begin failures++; $display("FAIL blank_bin got=%0d exp=150", value_bin); end
`endif
        $display("blank: blank=%b frames=%0d bcd=%h", blank, fv_count - fv_start, value_bcd);
    endtask

    task automatic test_error;
        fv_start = fv_count;
        scan(pat[0], pat[1], pat[9], 7'h55, 16);
        idle(8);
        checks++;
        if (value_bcd !== 16'h019F) begin failures++; $display("FAIL err_bcd got=%h exp=019f", value_bcd); end
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", frame_err); end
`ifdef SEG_READER_BIN_OUT_EN
        checks++;
        if (value_bin !== 14'd0) begin failures++; $display("FAIL err_bin got=%0d exp=0", value_bin); end
`endif
        $display("error: bcd=%h err=%b", value_bcd, frame_err);
        scan(pat[0], pat[1], pat[9], pat[9], 16);
        idle(8);
        checks++;
        if (value_bcd !== 16'h0199) begin failures++; $display("FAIL err_clean_bcd got=%h exp=0199", value_bcd); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL err_clean_flag got=%b exp=0", frame_err); end
        checks++;
        if (fv_count - fv_start !== 2) begin failures++; $display("FAIL err_pulses got=%0d exp=2", fv_count - fv_start); end
`ifdef SEG_READER_BIN_OUT_EN
        checks++;
        if (value_bin !== 14'd199) begin failures++; $display("FAIL err_clean_bin got=%0d exp=199", value_bin); end
`endif
        $display("error_clear: bcd=%h err=%b", value_bcd, frame_err);
    endtask

    task automatic test_mid_reset;
        hold(4'hE, pat[1], 4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (value_bcd !== 16'h0000) begin failures++; $display("FAIL midrst_bcd got=%h exp=0000", value_bcd); end
        checks++;
        if (frame_err !== 1'b0 || blank !== 1'b0 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flags got=%b%b%b exp=000", frame_err, blank, frame_valid);
        end
`ifdef SEG_READER_BIN_OUT_EN
        checks++;
        if (value_bin !== 14'd0) begin failures++; $display("FAIL midrst_bin got=%0d exp=0", value_bin); end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fv_start = fv_count;
        idle(4);
        scan(pat[4], pat[3], pat[2], pat[1], 16);
        idle(8);
        checks++;
        if (fv_count - fv_start !== 1) begin failures++; $display("FAIL midrst_pulses got=%0d exp=1", fv_count - fv_start); end
        checks++;
        if (value_bcd !== 16'h4321) begin failures++; $display("FAIL midrst_bcd2 got=%h exp=4321", value_bcd); end
        $display("mid_reset: frames=%0d bcd=%h", fv_count - fv_start, value_bcd);
    endtask

    initial begin
        pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        idle(4);
        test_basic;
        test_glitch;
        test_short_window;
        test_multi_low;
        test_blank;
        test_error;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
